// File: rtl/pwm_ramp_sequencer.sv
// Ramp sequencer driving the PWM duty input: steps from a start level to an end level
// with a programmable dwell per level, once or as a continuous triangle.
module pwm_ramp_sequencer #(
  parameter int DUTY_W = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_start,
  input  logic [DUTY_W-1:0] cfg_end,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              cfg_loop,
  input  logic              pause,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] lat_start;
  logic [DUTY_W-1:0] lat_end;
  logic [DUTY_W-1:0] lat_step;
  logic [HOLD_W-1:0] lat_hold;
  logic              lat_loop;
  logic              dir_up;
  logic [HOLD_W-1:0] dwell;

  logic [DUTY_W-1:0] swap_target;
  logic [DUTY_W-1:0] next_same;
  logic [DUTY_W-1:0] next_swap;

  // Saturating step toward tgt, computed one bit wider so it can neither wrap nor overshoot.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] stp,
    input logic              up
  );
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] thr;
    s   = (stp == '0) ? (DUTY_W+1)'(1) : {1'b0, stp};
    sum = {1'b0, cur} + s;
    thr = {1'b0, tgt} + s;
    if (up)
      return (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
    else
      return ({1'b0, cur} < thr) ? tgt : cur - s[DUTY_W-1:0];
  endfunction

  assign cfg_ready = (state == IDLE) && !abort;

  always_comb begin
    swap_target = (target == lat_end) ? lat_start : lat_end;
    next_same   = step_toward(duty_out, target, lat_step, dir_up);
    next_swap   = step_toward(duty_out, swap_target, lat_step, !dir_up);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      lat_start <= '0;
      lat_end   <= '0;
      lat_step  <= '0;
      lat_hold  <= '0;
      lat_loop  <= 1'b0;
      dir_up    <= 1'b0;
      dwell     <= '0;
      duty_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            lat_start <= cfg_start;
            lat_end   <= cfg_end;
            lat_step  <= cfg_step;
            lat_hold  <= cfg_hold;
            lat_loop  <= cfg_loop;
            target    <= cfg_end;
            dir_up    <= (cfg_end >= cfg_start);
            duty_out  <= cfg_start;
            dwell     <= cfg_hold;
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pause) begin
            if (dwell != '0) begin
              dwell <= dwell - 1'b1;
            end else if (duty_out != target) begin
              duty_out <= next_same;
              dwell    <= lat_hold;
            end else if (!lat_loop) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Endpoint reached in triangle mode: turn around and take the first step in one edge.
              target   <= swap_target;
              dir_up   <= !dir_up;
              duty_out <= next_swap;
              dwell    <= lat_hold;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
